// File: rtl/arf_out_fifo_pkg.sv
// rtl/arf_out_fifo_pkg.sv - shared constants and helpers for the arf output FIFO
package arf_out_fifo_pkg;

  localparam int ACK_PULSE_CYCLES = 1;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_ADDR_WIDTH   = 3;

  // Constant-evaluable ceil(log2(v)), used to validate addr_width against depth.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arf_out_fifo_if.sv
// rtl/arf_out_fifo_if.sv - req/ack/data handshake bundle with requester and responder views
interface arf_out_fifo_if #(
  parameter int DW = 32
) ();

  logic          req;
  logic          ack;
  logic [DW-1:0] data;

  // master issues req and receives ack+data; slave answers req with ack+data
  modport master (output req, input ack, input data);
  modport slave  (input req, output ack, output data);

endinterface

// File: rtl/arf_fifo_mem.sv
// rtl/arf_fifo_mem.sv - FIFO storage array, registered write and combinational read
module arf_fifo_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/arf_out_fifo.sv
// rtl/arf_out_fifo.sv - elastic buffer between an arf output port and a req/ack consumer
module arf_out_fifo
  import arf_out_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  arf_out_fifo_if.master        up,
  arf_out_fifo_if.slave         dn,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out
);

  if (ADDR_WIDTH != clog2(DEPTH) || DEPTH < 2 || (1 << ADDR_WIDTH) != DEPTH) begin : g_bad_params
    $error("arf_out_fifo: DEPTH must be a power of two >= 2 and ADDR_WIDTH = log2(DEPTH)");
  end

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  // Requests stay up only while two slots are free: one for the next ack, one for an ack in flight.
  localparam logic [ADDR_WIDTH:0]   LVL_REQ_MAX = (ADDR_WIDTH+1)'(DEPTH - 2);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_up_req;
  logic                  r_dn_ack;
  logic [DATA_WIDTH-1:0] r_dn_dout;
  logic                  r_overflow;
  logic [31:0]           r_count_in;
  logic [31:0]           r_count_out;

  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH:0]   w_level_next;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_full  = (r_level == LVL_FULL);
  assign w_wr_en = up.ack && !w_full;
  // Reads only from pre-edge occupancy, so a same-edge write never feeds the read.
  assign w_rd_en = dn.req && !r_dn_ack && (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  arf_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (up.data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_up_req    <= 1'b0;
      r_dn_ack    <= 1'b0;
      r_dn_dout   <= '0;
      r_overflow  <= 1'b0;
      r_count_in  <= '0;
      r_count_out <= '0;
    end else begin
      r_level  <= w_level_next;
      r_up_req <= (w_level_next <= LVL_REQ_MAX);
      r_dn_ack <= w_rd_en;
      if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
        r_count_in <= r_count_in + 32'd1;
      end
      if (up.ack && w_full) r_overflow <= 1'b1;
      if (w_rd_en) begin
        r_dn_dout   <= w_rdata;
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_count_out <= r_count_out + 32'd1;
      end
    end
  end

  assign up.req    = r_up_req;
  assign dn.ack    = r_dn_ack;
  assign dn.data   = r_dn_dout;
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = (r_level == '0);
  assign overflow  = r_overflow;
  assign count_in  = r_count_in;
  assign count_out = r_count_out;

endmodule

// File: tb/tb_arf_out_fifo.sv
// tb/tb_arf_out_fifo.sv - directed, table-driven bench for arf_out_fifo
module tb_arf_out_fifo;
  import arf_out_fifo_pkg::*;

  localparam int DW = 32, DEPTH = 8, AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arf_out_fifo_if #(.DW(DW)) up_if ();
  arf_out_fifo_if #(.DW(DW)) dn_if ();

  logic [AW:0] level;
  logic        full, empty, overflow;
  logic [31:0] count_in, count_out;

  arf_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up_if.master),
    .dn        (dn_if.slave),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .count_in  (count_in),
    .count_out (count_out)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        up_ack;
    logic [31:0] up_din;
    logic        dn_req;
    logic [3:0]  exp_level;
    logic        exp_dn_ack;
    logic [31:0] exp_dout;
    logic        exp_up_req;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    up_if.ack = 1'b0; up_if.data = '0; dn_if.req = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] v);
    up_if.ack = 1'b1; up_if.data = v;
    tick();
    up_if.ack = 1'b0;
    tick();
  endtask

  // Upstream answers each req with a single-cycle ack; consumer requests continuously.
  task automatic stream(input int n, input logic [31:0] base, input string tag);
    int sent = 0;
    int cyc = 0;
    dn_if.req = 1'b1;
    while ((sent < n || sb.size() > 0) && cyc < 2000) begin
      if (dn_if.ack) begin
        if (sb.size() == 0) chk({tag, "_unexpected_ack"}, 32'd1, 32'd0);
        else chk({tag, "_data"}, dn_if.data, sb.pop_front());
      end
      up_if.ack = up_if.req && !up_if.ack && (sent < n);
      if (up_if.ack) begin
        up_if.data = base + sent;
        sb.push_back(base + sent);
        sent++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 2000) chk({tag, "_timeout"}, 32'd1, 32'd0);
    up_if.ack = 1'b0;
    dn_if.req = 1'b0;
    tick();
  endtask

  task automatic drain8(input logic [31:0] base, input string tag);
    int pulses = 0;
    int last = 0;
    int dead = 0;
    dn_if.req = 1'b1;
    for (int c = 0; c < 40 && pulses < 8; c++) begin
      tick();
      if (dn_if.ack) begin
        chk({tag, "_data"}, dn_if.data, base + pulses);
        if (dn_if.data == 32'hDEAD) dead++;
        if (pulses > 0) chk({tag, "_gap"}, c - last, 2);
        last = c;
        pulses++;
        if (level == 4'd7) chk({tag, "_upreq_at7"}, up_if.req, 1'b0);
        if (level == 4'd6) chk({tag, "_upreq_at6"}, up_if.req, 1'b1);
      end
    end
    dn_if.req = 1'b0;
    chk({tag, "_pulses"}, pulses, 8);
    chk({tag, "_no_dead"}, dead, 0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_upreq_end"}, up_if.req, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'hA1, 1'b0, 4'd1, 1'b0, 32'h0,  1'b1};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 4'd0, 1'b1, 32'hA1, 1'b1};
    vecs[2] = '{1'b1, 32'hB2, 1'b1, 4'd1, 1'b0, 32'hA1, 1'b1};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 4'd0, 1'b1, 32'hB2, 1'b1};
    vecs[4] = '{1'b1, 32'hC3, 1'b0, 4'd1, 1'b0, 32'hB2, 1'b1};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 4'd1, 1'b0, 32'hB2, 1'b1};
    vecs[6] = '{1'b1, 32'hD4, 1'b1, 4'd1, 1'b1, 32'hC3, 1'b1};
    vecs[7] = '{1'b0, 32'h0,  1'b1, 4'd1, 1'b0, 32'hC3, 1'b1};
    vecs[8] = '{1'b0, 32'h0,  1'b1, 4'd0, 1'b1, 32'hD4, 1'b1};
    vecs[9] = '{1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 32'hD4, 1'b1};

    // Reset state, then first request after release.
    rst = 1'b0;
    up_if.ack = 1'b0; up_if.data = '0; dn_if.req = 1'b0;
    repeat (3) tick();
    chk("rst_up_req", up_if.req, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_dn_ack", dn_if.ack, 1'b0);
    chk("rst_dout", dn_if.data, 32'h0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b1;
    tick();
    chk("release_up_req", up_if.req, 1'b1);

    for (int i = 0; i < 10; i++) begin
      up_if.ack = vecs[i].up_ack;
      up_if.data = vecs[i].up_din;
      dn_if.req = vecs[i].dn_req;
      tick();
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("vec%0d_dn_ack", i), dn_if.ack, vecs[i].exp_dn_ack);
      chk($sformatf("vec%0d_dout", i), dn_if.data, vecs[i].exp_dout);
      chk($sformatf("vec%0d_up_req", i), up_if.req, vecs[i].exp_up_req);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_level == 4'd0);
    end
    chk("vec_count_in", count_in, 32'd4);
    chk("vec_count_out", count_out, 32'd4);

    // Stream pass-through of 0..19.
    do_reset();
    stream(20, 32'd0, "stream");
    chk("stream_count_in", count_in, 32'd20);
    chk("stream_count_out", count_out, 32'd20);
    chk("stream_overflow", overflow, 1'b0);

    // Fill to capacity with no consumer.
    do_reset();
    begin
      int v = 0;
      int c = 0;
      while (!(up_if.req == 1'b0 && up_if.ack == 1'b0) && c < 100) begin
        up_if.ack = up_if.req && !up_if.ack;
        if (up_if.ack) begin up_if.data = v; v++; end
        tick();
        c++;
      end
      if (c >= 100) chk("fill_timeout", 32'd1, 32'd0);
    end
    chk("fill_level7", level, 4'd7);
    chk("fill_up_req_low", up_if.req, 1'b0);
    chk("fill_not_full", full, 1'b0);
    up_if.ack = 1'b1; up_if.data = 32'd7;
    tick();
    up_if.ack = 1'b0;
    chk("fill_level8", level, 4'd8);
    chk("fill_full", full, 1'b1);
    chk("fill_overflow", overflow, 1'b0);
    chk("fill_count_in", count_in, 32'd8);

    // Drain from full.
    drain8(32'd0, "drain");
    chk("drain_count_out", count_out, 32'd8);

    // Simultaneous push/pop at level 4, then wrap-around traffic.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'd200 + i);
      sb.push_back(32'd200 + i);
    end
    chk("sim_level4", level, 4'd4);
    up_if.ack = 1'b1; up_if.data = 32'd204; dn_if.req = 1'b1;
    sb.push_back(32'd204);
    tick();
    up_if.ack = 1'b0; dn_if.req = 1'b0;
    chk("sim_level_hold", level, 4'd4);
    chk("sim_dn_ack", dn_if.ack, 1'b1);
    chk("sim_dout", dn_if.data, sb.pop_front());
    tick();
    stream(30, 32'd300, "wrap");
    chk("wrap_count_in", count_in, 32'd35);
    chk("wrap_count_out", count_out, 32'd35);
    chk("wrap_empty", empty, 1'b1);
    chk("wrap_overflow", overflow, 1'b0);

    // Protocol violation while full, then asynchronous reset.
    do_reset();
    for (int i = 0; i < 8; i++) push(32'd100 + i);
    chk("ovf_full", full, 1'b1);
    up_if.ack = 1'b1; up_if.data = 32'hDEAD;
    tick();
    up_if.ack = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count_in", count_in, 32'd8);
    chk("ovf_level", level, 4'd8);
    tick();
    chk("ovf_sticky", overflow, 1'b1);
    drain8(32'd100, "ovf_drain");
    chk("ovf_sticky_after_drain", overflow, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_level", level, 4'd0);
    chk("arst_count_in", count_in, 32'd0);
    chk("arst_count_out", count_out, 32'd0);
    chk("arst_up_req", up_if.req, 1'b0);
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
